// File: rtl/riscv_imm_pkg.sv
// Shared immediate-format definitions for the packer, extender and decoder.
// The range check lives here so every consumer agrees on what is representable.
package riscv_imm_pkg;

  localparam int FIELD_W = 25;

  typedef logic [2:0] imm_format_t;

  localparam imm_format_t FMT_R  = 3'd0;
  localparam imm_format_t FMT_I  = 3'd1;
  localparam imm_format_t FMT_S  = 3'd2;
  localparam imm_format_t FMT_U  = 3'd3;
  localparam imm_format_t FMT_SB = 3'd4;
  localparam imm_format_t FMT_UJ = 3'd5;

  // True when imm[31:msb] is a pure sign extension of imm[msb].
  function automatic logic fits_signed(input logic [31:0] imm, input int msb);
    logic signed [31:0] t;
    t = $signed(imm) >>> msb;
    return (t == 32'sd0) || (t == -32'sd1);
  endfunction

  function automatic logic imm_range_error(input logic [31:0] imm, input imm_format_t fmt);
    logic err;
    err = 1'b1;
    case (fmt)
      FMT_R:         err = 1'b0;
      FMT_I, FMT_S:  err = !fits_signed(imm, 11);
      FMT_U:         err = (imm[11:0] != 12'd0);
      FMT_SB:        err = imm[0] || !fits_signed(imm, 12);
      FMT_UJ:        err = imm[0] || !fits_signed(imm, 20);
      default:       err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/imm_field_pack.sv
// Combinational packer: scatters an immediate into instr[31:7] for a format.
// Out-of-range values are still packed from their truncated bits.
module imm_field_pack
  import riscv_imm_pkg::*;
(
  input  logic [31:0]        value,
  input  imm_format_t        format,
  output logic [FIELD_W-1:0] field,
  output logic               range_error
);

  always_comb begin
    field = '0;
    case (format)
      FMT_I: field[24:13] = value[11:0];
      FMT_S: begin
        field[24:18] = value[11:5];
        field[4:0]   = value[4:0];
      end
      FMT_U: field[24:5] = value[31:12];
      FMT_SB: begin
        field[24]    = value[12];
        field[23:18] = value[10:5];
        field[4:1]   = value[4:1];
        field[0]     = value[11];
      end
      FMT_UJ: begin
        field[24]    = value[20];
        field[23:18] = value[10:5];
        field[17:14] = value[4:1];
        field[13]    = value[11];
        field[12:5]  = value[19:12];
      end
      default: field = '0;
    endcase
  end

  assign range_error = imm_range_error(value, format);

endmodule

// File: rtl/imm_packer.sv
// Two-stage valid/ready immediate packer with saturating pack/error counters.
// Stage 1 holds the raw value plus its range flag; stage 2 holds the packed field.
module imm_packer #(
  parameter int FIELD_W = 25,
  parameter int CNT_W   = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [31:0]        IMM_VALUE,
  input  logic [2:0]         IMM_FORMAT,
  input  logic               IN_VALID,
  output logic               IN_READY,
  output logic [FIELD_W-1:0] IMM_FIELD,
  output logic               RANGE_ERROR,
  output logic               OUT_VALID,
  input  logic               OUT_READY,
  input  logic               COUNT_CLEAR,
  output logic [CNT_W-1:0]   PACK_COUNT,
  output logic [CNT_W-1:0]   ERROR_COUNT
);

  logic                       s1_v, s2_v;
  logic [31:0]                s1_value;
  riscv_imm_pkg::imm_format_t s1_format;
  logic                       s1_err;
  logic [FIELD_W-1:0]         s2_field;
  logic                       s2_err;
  logic [FIELD_W-1:0]         pack_field;
  logic                       pack_err_unused;
  logic                       in_fire, out_fire, s2_load;

  assign IN_READY = !s1_v || !s2_v || OUT_READY;
  assign in_fire  = IN_VALID && IN_READY;
  assign out_fire = s2_v && OUT_READY;
  // Stage 1 moves forward only when stage 2 is empty or draining this cycle.
  assign s2_load  = s1_v && (!s2_v || OUT_READY);

  imm_field_pack u_pack (
    .value       (s1_value),
    .format      (s1_format),
    .field       (pack_field),
    .range_error (pack_err_unused)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1_v      <= 1'b0;
      s1_value  <= '0;
      s1_format <= riscv_imm_pkg::FMT_R;
      s1_err    <= 1'b0;
    end else if (in_fire) begin
      s1_v      <= 1'b1;
      s1_value  <= IMM_VALUE;
      s1_format <= IMM_FORMAT;
      s1_err    <= riscv_imm_pkg::imm_range_error(IMM_VALUE, IMM_FORMAT);
    end else if (s2_load) begin
      s1_v <= 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s2_v     <= 1'b0;
      s2_field <= '0;
      s2_err   <= 1'b0;
    end else if (s2_load) begin
      s2_v     <= 1'b1;
      s2_field <= pack_field;
      s2_err   <= s1_err;
    end else if (OUT_READY) begin
      s2_v <= 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      PACK_COUNT  <= '0;
      ERROR_COUNT <= '0;
    end else if (COUNT_CLEAR) begin
      PACK_COUNT  <= '0;
      ERROR_COUNT <= '0;
    end else if (out_fire) begin
      if (s2_err) begin
        if (ERROR_COUNT != '1) ERROR_COUNT <= ERROR_COUNT + 1'b1;
      end else begin
        if (PACK_COUNT != '1) PACK_COUNT <= PACK_COUNT + 1'b1;
      end
    end
  end

  assign OUT_VALID   = s2_v;
  assign IMM_FIELD   = s2_field;
  assign RANGE_ERROR = s2_err;

endmodule
